move_scheduler: RTL and testbench

MOVE_SCHEDULER -- requirements
Module: move_scheduler

---
 rtl/move_scheduler_pkg.sv | 48 ++++
 rtl/move_scheduler_if.sv | 28 ++
 rtl/move_scheduler_btn_debounce.sv | 69 ++++++
 rtl/move_scheduler.sv | 155 +++++++++++++++
 tb/tb_move_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/move_scheduler_pkg.sv
// Shared definitions for the move scheduler and the game state machine:
// direction encodings, scheduler FSM states and small helpers.
package move_scheduler_pkg;

    // Direction code carried on move_dir.
    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    // Scheduler FSM states.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DEBOUNCE  = 3'd1,
        ISSUE     = 3'd2,
        WAIT_DONE = 3'd3,
        RELEASE   = 3'd4
    } state_t;

    // Button bus layout: bit index equals the direction code.
    localparam int unsigned BTN_W = 4;
    localparam int unsigned BIT_U = 0;
    localparam int unsigned BIT_D = 1;
    localparam int unsigned BIT_L = 2;
    localparam int unsigned BIT_R = 3;

    localparam logic [7:0] TIMEOUT_MAX = 8'hFF;

    // Fixed priority U > D > L > R.
    function automatic dir_t prio_dir(input logic [BTN_W-1:0] pat);
        dir_t d;
        if (pat[BIT_U])      d = DIR_UP;
        else if (pat[BIT_D]) d = DIR_DOWN;
        else if (pat[BIT_L]) d = DIR_LEFT;
        else                 d = DIR_RIGHT;
        return d;
    endfunction

    // Single-button pattern that corresponds to a direction.
    function automatic logic [BTN_W-1:0] dir_onehot(input dir_t d);
        logic [BTN_W-1:0] one;
        one = 4'b0001;
        return one << d;
    endfunction

endpackage

// File: rtl/move_scheduler_if.sv
// Move request handshake between the scheduler (master) and the game
// state machine (slave), plus the game status lines the scheduler watches.
interface move_scheduler_if;
    import move_scheduler_pkg::*;

    logic move_valid;
    dir_t move_dir;
    logic move_ready;
    logic game_busy;
    logic game_over;

    modport master (
        output move_valid,
        output move_dir,
        input  move_ready,
        input  game_busy,
        input  game_over
    );

    modport slave (
        input  move_valid,
        input  move_dir,
        output move_ready,
        output game_busy,
        output game_over
    );

endinterface

// File: rtl/move_scheduler_btn_debounce.sv
// btn_debounce: two-flop synchronizer per button followed by a stability
// counter on the whole bus. 'stable' only takes a pattern after it has been
// seen unchanged for DEB_CYCLES consecutive synced samples; 'settled' is high
// while the current synced pattern is the accepted one.
module btn_debounce #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DEB_CYCLES = 3
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] btn,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] stable,
    output logic             settled
);
    localparam int unsigned     CNT_W    = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEB_CYCLES);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            // Two-flop synchronizer for one asynchronous button.
            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= btn[gi];
                    sync_reg <= meta_reg;
                end
            end
            assign sync[gi] = sync_reg;
        end
    endgenerate

    logic [WIDTH-1:0] cand_reg;
    logic [WIDTH-1:0] stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    // Count consecutive identical samples; a new pattern counts as its first.
    always_comb begin
        cnt_next = CNT_W'(1);
        if (sync == cand_reg) begin
            cnt_next = (cnt_reg == CNT_DONE) ? cnt_reg : cnt_reg + 1'b1;
        end
    end

    // Candidate, run length and accepted pattern registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cand_reg   <= '0;
            cnt_reg    <= '0;
            stable_reg <= '0;
        end else begin
            cand_reg <= sync;
            cnt_reg  <= cnt_next;
            if (cnt_next == CNT_DONE) begin
                stable_reg <= sync;
            end
        end
    end

    assign stable  = stable_reg;
    assign settled = (cnt_reg == CNT_DONE);

endmodule

// File: rtl/move_scheduler.sv
// move_scheduler: turns debounced direction buttons into one move request
// per press on a valid/ready handshake toward the game state machine.
// Optional feature macro: MOVE_AUTOREPEAT_EN (hold-to-repeat in RELEASE).
module move_scheduler
    import move_scheduler_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 3
`ifdef MOVE_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_CYCLES = 48
`endif
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             BtnU,
    input  logic             BtnD,
    input  logic             BtnL,
    input  logic             BtnR,
    move_scheduler_if.master mv
);
    logic [BTN_W-1:0] btn_raw;
    logic [BTN_W-1:0] btn_sync;
    logic [BTN_W-1:0] btn_stable;
    logic             btn_settled;
    logic             released;
    logic             pressed;
    logic             rep_fire;

    state_t     state_reg, state_next;
    dir_t       dir_reg, dir_next;
    logic [7:0] to_cnt_reg, to_cnt_next;
    // Cleared by reset: buttons must be seen released before any move.
    logic       armed_reg, armed_next;

    assign btn_raw = {BtnR, BtnL, BtnD, BtnU};

    btn_debounce #(
        .WIDTH      (BTN_W),
        .DEB_CYCLES (DEB_CYCLES)
    ) u_btn_debounce (
        .clk     (Clk),
        .reset_n (Reset),
        .btn     (btn_raw),
        .sync    (btn_sync),
        .stable  (btn_stable),
        .settled (btn_settled)
    );

    assign released = btn_settled && (btn_stable == '0);
    assign pressed  = btn_settled && (btn_stable != '0);

`ifdef MOVE_AUTOREPEAT_EN
    localparam int unsigned REP_W = $clog2(REPEAT_CYCLES + 1);
    logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;
    logic             rep_hold;

    // Repeat timer: runs while the issued direction alone stays held in RELEASE.
    always_comb begin
        rep_hold     = (state_reg == RELEASE) && btn_settled && !mv.game_over &&
                       (btn_stable == dir_onehot(dir_reg));
        rep_fire     = rep_hold && (rep_cnt_reg == REP_W'(REPEAT_CYCLES - 1));
        rep_cnt_next = (rep_hold && !rep_fire) ? rep_cnt_reg + 1'b1 : '0;
    end

    // Repeat counter register.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            rep_cnt_reg <= '0;
        end else begin
            rep_cnt_reg <= rep_cnt_next;
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // Next-state logic; game_over steers to RELEASE except for a transfer in flight.
    always_comb begin
        state_next  = state_reg;
        dir_next    = dir_reg;
        to_cnt_next = '0;
        armed_next  = armed_reg;
        case (state_reg)
            IDLE: begin
                if (mv.game_over) begin
                    state_next = RELEASE;
                end else if (!armed_reg) begin
                    // First look after reset: a held button goes to RELEASE.
                    if (btn_sync != '0) begin
                        state_next = RELEASE;
                    end else if (released) begin
                        armed_next = 1'b1;
                    end
                end else if ((btn_sync != '0) && !mv.game_busy) begin
                    state_next = DEBOUNCE;
                end
            end
            DEBOUNCE: begin
                if (mv.game_over) begin
                    state_next = RELEASE;
                end else if (pressed) begin
                    state_next = ISSUE;
                    dir_next   = prio_dir(btn_stable);
                end else if (released) begin
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                if (mv.move_ready) begin
                    state_next = WAIT_DONE;
                end else if (mv.game_over) begin
                    state_next = RELEASE;
                end
            end
            WAIT_DONE: begin
                to_cnt_next = (to_cnt_reg == TIMEOUT_MAX) ? to_cnt_reg : to_cnt_reg + 8'd1;
                if (mv.game_over || !mv.game_busy || (to_cnt_reg == TIMEOUT_MAX)) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                if (mv.game_over) begin
                    state_next = RELEASE;
                end else if (released) begin
                    state_next = IDLE;
                    armed_next = 1'b1;
                end else if (rep_fire) begin
                    state_next = ISSUE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, latched direction, timeout and arm flag registers.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_reg  <= IDLE;
            dir_reg    <= DIR_UP;
            to_cnt_reg <= '0;
            armed_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            dir_reg    <= dir_next;
            to_cnt_reg <= to_cnt_next;
            armed_reg  <= armed_next;
        end
    end

    assign mv.move_valid = (state_reg == ISSUE);
    assign mv.move_dir   = dir_reg;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed testbench for move_scheduler: press scenarios, bounce, stall,
// game_over lockout, reset behaviour and hold-to-repeat move count.
`timescale 1ns/1ps
module tb_move_scheduler;
    import move_scheduler_pkg::*;

`ifdef MOVE_AUTOREPEAT_EN
    localparam int EXP_HOLD_MOVES = 4;
`else
    localparam int EXP_HOLD_MOVES = 1;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic btn_u, btn_d, btn_l, btn_r;

    move_scheduler_if mif ();

    move_scheduler dut (
        .Clk   (clk),
        .Reset (rst_n),
        .BtnU  (btn_u),
        .BtnD  (btn_d),
        .BtnL  (btn_l),
        .BtnR  (btn_r),
        .mv    (mif)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int xfers        = 0;
    int valid_cycles = 0;
    logic [1:0] last_dir = 2'b00;
    int busy_len  = 0;
    int busy_left = 0;

    // Transfer monitor: one line per accepted move.
    always @(negedge clk) begin
        if (mif.move_valid === 1'b1) begin
            valid_cycles++;
            if (mif.move_ready === 1'b1) begin
                xfers++;
                last_dir = mif.move_dir;
                $display("[TB] t=%0t move dir=%0d", $time, mif.move_dir);
            end
        end
    end

    // One clock; optionally emulates game_busy for busy_len cycles after a transfer.
    task automatic step();
        @(negedge clk);
        if (busy_len > 0 && mif.move_valid === 1'b1 && mif.move_ready === 1'b1)
            busy_left = busy_len;
        @(posedge clk);
        #1;
        if (busy_len > 0) begin
            mif.game_busy = (busy_left > 0);
            if (busy_left > 0) busy_left--;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic set_btn(input logic [3:0] p);
        {btn_r, btn_l, btn_d, btn_u} = p;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_btn(4'b0000);
        mif.move_ready = 1'b0;
        mif.game_busy  = 1'b0;
        mif.game_over  = 1'b0;
        steps(3);
        tests_run++;
        if (mif.move_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_valid got=%b exp=0", mif.move_valid);
        end
        tests_run++;
        if (mif.move_dir !== DIR_UP) begin
            tests_failed++;
            $display("FAIL reset_dir got=%0d exp=0", mif.move_dir);
        end
        rst_n = 1'b1;
        steps(8);
        tests_run++;
        if (mif.move_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_valid got=%b exp=0", mif.move_valid);
        end
    endtask

    task automatic test_single_press();
        int x0, v0;
        x0 = xfers; v0 = valid_cycles;
        mif.move_ready = 1'b1;
        set_btn(4'b0100);
        steps(5);
        tests_run++;
        if (mif.move_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL single_early got=%b exp=0", mif.move_valid);
        end
        step();
        tests_run++;
        if (mif.move_valid !== 1'b1 || mif.move_dir !== DIR_LEFT) begin
            tests_failed++;
            $display("FAIL single_issue valid=%b dir=%0d exp valid=1 dir=2", mif.move_valid, mif.move_dir);
        end
        steps(4);
        set_btn(4'b0000);
        steps(15);
        tests_run++;
        if (xfers - x0 != 1 || valid_cycles - v0 != 1) begin
            tests_failed++;
            $display("FAIL single_count xfers=%0d valid_cycles=%0d exp 1 1", xfers - x0, valid_cycles - v0);
        end
        tests_run++;
        if (last_dir !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_dir got=%0d exp=2", last_dir);
        end
    endtask

    task automatic test_simultaneous();
        int x0;
        x0 = xfers;
        set_btn(4'b1001);
        steps(10);
        tests_run++;
        if (xfers - x0 != 1 || last_dir !== 2'b00) begin
            tests_failed++;
            $display("FAIL simul_first xfers=%0d dir=%0d exp 1 0", xfers - x0, last_dir);
        end
        set_btn(4'b1000);
        steps(15);
        tests_run++;
        if (xfers - x0 != 1) begin
            tests_failed++;
            $display("FAIL simul_no_right xfers=%0d exp=1", xfers - x0);
        end
        set_btn(4'b0000);
        steps(15);
        set_btn(4'b1000);
        steps(10);
        set_btn(4'b0000);
        steps(15);
        tests_run++;
        if (xfers - x0 != 2 || last_dir !== 2'b11) begin
            tests_failed++;
            $display("FAIL simul_repress xfers=%0d dir=%0d exp 2 3", xfers - x0, last_dir);
        end
    endtask

    task automatic test_bounce();
        int x0, v0;
        x0 = xfers; v0 = valid_cycles;
        for (int i = 0; i < 8; i++) begin
            set_btn((i % 2 == 0) ? 4'b0010 : 4'b0000);
            step();
        end
        set_btn(4'b0010);
        steps(5);
        tests_run++;
        if (mif.move_valid !== 1'b0 || valid_cycles - v0 != 0) begin
            tests_failed++;
            $display("FAIL bounce_early valid=%b cycles=%0d exp 0 0", mif.move_valid, valid_cycles - v0);
        end
        step();
        tests_run++;
        if (mif.move_valid !== 1'b1 || mif.move_dir !== DIR_DOWN) begin
            tests_failed++;
            $display("FAIL bounce_issue valid=%b dir=%0d exp valid=1 dir=1", mif.move_valid, mif.move_dir);
        end
        steps(10);
        set_btn(4'b0000);
        steps(15);
        tests_run++;
        if (xfers - x0 != 1) begin
            tests_failed++;
            $display("FAIL bounce_count xfers=%0d exp=1", xfers - x0);
        end
    endtask

    task automatic test_stall();
        int x0;
        x0 = xfers;
        mif.move_ready = 1'b0;
        set_btn(4'b0001);
        steps(6);
        tests_run++;
        if (mif.move_valid !== 1'b1 || mif.move_dir !== DIR_UP) begin
            tests_failed++;
            $display("FAIL stall_issue valid=%b dir=%0d exp valid=1 dir=0", mif.move_valid, mif.move_dir);
        end
        set_btn(4'b0010);
        for (int i = 0; i < 20; i++) begin
            step();
            tests_run++;
            if (mif.move_valid !== 1'b1 || mif.move_dir !== DIR_UP) begin
                tests_failed++;
                $display("FAIL stall_hold cyc=%0d valid=%b dir=%0d exp valid=1 dir=0", i, mif.move_valid, mif.move_dir);
            end
        end
        mif.move_ready = 1'b1;
        steps(3);
        tests_run++;
        if (mif.move_valid !== 1'b0 || xfers - x0 != 1 || last_dir !== 2'b00) begin
            tests_failed++;
            $display("FAIL stall_done valid=%b xfers=%0d dir=%0d exp 0 1 0", mif.move_valid, xfers - x0, last_dir);
        end
        set_btn(4'b0000);
        steps(15);
    endtask

    task automatic test_game_over();
        int x0, v0;
        x0 = xfers; v0 = valid_cycles;
        mif.game_over = 1'b1;
        steps(3);
        set_btn(4'b1000);
        steps(15);
        tests_run++;
        if (mif.move_valid !== 1'b0 || valid_cycles - v0 != 0) begin
            tests_failed++;
            $display("FAIL over_block valid=%b cycles=%0d exp 0 0", mif.move_valid, valid_cycles - v0);
        end
        mif.game_over = 1'b0;
        steps(10);
        tests_run++;
        if (valid_cycles - v0 != 0) begin
            tests_failed++;
            $display("FAIL over_held cycles=%0d exp=0", valid_cycles - v0);
        end
        set_btn(4'b0000);
        steps(15);
        set_btn(4'b1000);
        steps(10);
        set_btn(4'b0000);
        steps(15);
        tests_run++;
        if (xfers - x0 != 1 || last_dir !== 2'b11) begin
            tests_failed++;
            $display("FAIL over_repress xfers=%0d dir=%0d exp 1 3", xfers - x0, last_dir);
        end
    endtask

    task automatic test_reset_mid();
        int x0, v0;
        mif.move_ready = 1'b0;
        set_btn(4'b0100);
        steps(6);
        tests_run++;
        if (mif.move_valid !== 1'b1 || mif.move_dir !== DIR_LEFT) begin
            tests_failed++;
            $display("FAIL rstmid_issue valid=%b dir=%0d exp valid=1 dir=2", mif.move_valid, mif.move_dir);
        end
        rst_n = 1'b0;
        step();
        tests_run++;
        if (mif.move_valid !== 1'b0 || mif.move_dir !== DIR_UP) begin
            tests_failed++;
            $display("FAIL rstmid_drop valid=%b dir=%0d exp valid=0 dir=0", mif.move_valid, mif.move_dir);
        end
        steps(2);
        rst_n = 1'b1;
        x0 = xfers; v0 = valid_cycles;
        mif.move_ready = 1'b1;
        steps(20);
        tests_run++;
        if (valid_cycles - v0 != 0) begin
            tests_failed++;
            $display("FAIL rstmid_held cycles=%0d exp=0", valid_cycles - v0);
        end
        set_btn(4'b0000);
        steps(15);
        set_btn(4'b0100);
        steps(10);
        set_btn(4'b0000);
        steps(15);
        tests_run++;
        if (xfers - x0 != 1 || last_dir !== 2'b10) begin
            tests_failed++;
            $display("FAIL rstmid_repress xfers=%0d dir=%0d exp 1 2", xfers - x0, last_dir);
        end
    endtask

    task automatic test_hold_repeat();
        int x0, v0;
        x0 = xfers; v0 = valid_cycles;
        mif.move_ready = 1'b1;
        busy_len  = 2;
        busy_left = 0;
        set_btn(4'b0001);
        steps(200);
        set_btn(4'b0000);
        steps(20);
        busy_len = 0;
        mif.game_busy = 1'b0;
        tests_run++;
        if (xfers - x0 != EXP_HOLD_MOVES || valid_cycles - v0 != EXP_HOLD_MOVES) begin
            tests_failed++;
            $display("FAIL hold_moves xfers=%0d valid_cycles=%0d exp=%0d", xfers - x0, valid_cycles - v0, EXP_HOLD_MOVES);
        end
        tests_run++;
        if (last_dir !== 2'b00) begin
            tests_failed++;
            $display("FAIL hold_dir got=%0d exp=0", last_dir);
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_simultaneous();
        test_bounce();
        test_stall();
        test_game_over();
        test_reset_mid();
        test_hold_repeat();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Global time bound so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog time=%0t limit=200000", $time);
        $fatal(1, "watchdog");
    end

endmodule
